// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment per stage, full-pipeline stall.
// Define CLA_PIPE_OVF_EN to enable signed-overflow reporting on ovf; otherwise ovf is tied to 0.
module cla_pipe_addsub #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG;

    // Segment add built from 4-bit lookahead groups; SEG must be a multiple of 4.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c0);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = c0;
        for (int j = 0; j < SEG; j += 4) begin
            c[j+1] = g[j] | (p[j] & c[j]);
            c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & c[j]);
            c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j])
                   | (p[j+2] & p[j+1] & p[j] & c[j]);
            c[j+4] = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1])
                   | (p[j+3] & p[j+2] & p[j+1] & g[j])
                   | (p[j+3] & p[j+2] & p[j+1] & p[j] & c[j]);
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic             vld_p [NSEG];
    logic [WIDTH-1:0] sum_p [NSEG];
    logic [WIDTH-1:0] opa_p [NSEG];
    logic [WIDTH-1:0] opb_p [NSEG];
    logic             cy_p  [NSEG];

    logic             vld_n [NSEG];
    logic [WIDTH-1:0] sum_n [NSEG];
    logic [WIDTH-1:0] opa_n [NSEG];
    logic [WIDTH-1:0] opb_n [NSEG];
    logic             cy_n  [NSEG];

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             stall;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic [SEG:0]     seg_r;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf_p;
    logic             ovf_n;
`endif

    assign out_valid = vld_p[NSEG-1];
    assign s         = sum_p[NSEG-1];
    assign c_out     = cy_p[NSEG-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign b_eff     = op[1] ? ~b : b;
    assign c_eff     = op[0] ? cin : op[1];

    always_comb begin
        src_a = '0;
        src_b = '0;
        src_s = '0;
        src_c = 1'b0;
        seg_r = '0;
`ifdef CLA_PIPE_OVF_EN
        ovf_n = 1'b0;
`endif
        for (int k = 0; k < NSEG; k++) begin
            if (k == 0) begin
                src_a    = a;
                src_b    = b_eff;
                src_s    = '0;
                src_c    = c_eff;
                vld_n[k] = in_valid;
            end else begin
                src_a    = opa_p[k-1];
                src_b    = opb_p[k-1];
                src_s    = sum_p[k-1];
                src_c    = cy_p[k-1];
                vld_n[k] = vld_p[k-1];
            end
            seg_r                 = cla_seg(src_a[k*SEG +: SEG], src_b[k*SEG +: SEG], src_c);
            sum_n[k]              = src_s;
            sum_n[k][k*SEG +: SEG] = seg_r[SEG-1:0];
            cy_n[k]               = seg_r[SEG];
            opa_n[k]              = src_a;
            opb_n[k]              = src_b;
`ifdef CLA_PIPE_OVF_EN
            // Top segment carries the sign bits; overflow is decided there.
            if (k == NSEG - 1)
                ovf_n = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (seg_r[SEG-1] != src_a[WIDTH-1]);
`endif
        end
    end

    // Stage boundary: every stage shifts together unless the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_p[k] <= 1'b0;
                sum_p[k] <= '0;
                opa_p[k] <= '0;
                opb_p[k] <= '0;
                cy_p[k]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_p[k] <= vld_n[k];
                sum_p[k] <= sum_n[k];
                opa_p[k] <= opa_n[k];
                opb_p[k] <= opb_n[k];
                cy_p[k]  <= cy_n[k];
            end
        end
    end

`ifdef CLA_PIPE_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_p <= 1'b0;
        else if (!stall)
            ovf_p <= ovf_n;
    end
    assign ovf = ovf_p;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub (WIDTH=64, SEG=16, latency 4).
module tb_cla_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] s;
    logic        c_out;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CLA_PIPE_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    cla_pipe_addsub #(.WIDTH(64), .SEG(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated beat: accept, confirm nothing at cycle 3, result at cycle 4.
    task automatic run_one(input string tag, input logic [1:0] o, input logic [63:0] x,
                           input logic [63:0] y, input logic ci, input logic [63:0] es,
                           input logic ec, input logic eo);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; cin = ci; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_s"}, s, es);
        check({tag, "_cout"}, 64'(c_out), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    initial begin
        int idx;
        int got;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 2'b00; cin = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_s", s, 64'd0);
        check("rst_cout", 64'(c_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("add_ripple", 2'b00, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h0001_0000_0000_0000, 1'b0, 1'b0);
        run_one("sub_borrow", 2'b10, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("sbc", 2'b11, 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
        run_one("adc_wrap", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
        run_one("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, OVF_ON);

        // Streaming with out_ready low on cycles 5..7.
        idx = 0; got = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (idx < 8);
            a = 64'(idx); b = 64'd100; op = 2'b00; cin = 1'b0;
            #1;
            check("stream_rdy", 64'(in_ready), (cyc >= 5 && cyc <= 7) ? 64'd0 : 64'd1);
            if (out_valid && out_ready) begin
                check("stream_s", s, 64'(100 + got));
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_cnt", 64'(got), 64'd8);

        // Bubbles: valid pattern 1/0 must reappear 4 cycles later.
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (cyc < 6) && (cyc % 2 == 0);
            a = 64'(cyc); b = 64'd0; op = 2'b00;
            #1;
            if (cyc >= 4 && cyc < 10) begin
                check("bubble_vld", 64'(out_valid), (cyc % 2 == 0) ? 64'd1 : 64'd0);
                if (cyc % 2 == 0) check("bubble_s", s, 64'(cyc - 4));
            end
        end
        in_valid = 1'b0;

        // Reset with carry-producing beats in flight.
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 4);
            a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd2; op = 2'b00; cin = 1'b0;
        end
        in_valid = 1'b0;
        #1;
        check("midrst_pre_vld", 64'(out_valid), 64'd1);
        check("midrst_pre_s", s, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_vld", 64'(out_valid), 64'd0);
        check("midrst_s", s, 64'd0);
        check("midrst_cout", 64'(c_out), 64'd0);
        check("midrst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_one("adc_post_rst", 2'b01, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        // No residual beats may emerge after the post-reset one.
        repeat (6) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
